service_time_monitor: RTL and testbench

//  Opposite end of the service-pricing path. The pricing block consumes a time-exceeded flag (ex)
//  and this block produces it. It accepts a service job (6-bit service mask plus allotted time),

---
 rtl/service_time_monitor.sv | 178 +++++++++++++++++
 tb/tb_service_time_monitor.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/service_time_monitor.sv
// ---------------------------------------------------------------------------
// service_time_monitor
//
// Accepts a service job (service mask + allotted time units), times it in
// real clock ticks until the station reports completion, and raises ex while
// the job runs past its allotted time. When a job closes it reports the
// elapsed time and the overrun beyond the allotment, which feed the pricing
// block's cost-return logic.
//
// Timing of an accepted job:
//   Cycle 0 is the first cycle after the accept edge.
//   TICK_DIV cycles make one time unit.
//   The cycle in which the registered elapsed count first equals the allotment
//   moves the block to OVERTIME, and ex is high from the following cycle.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   job_valid     job offered
//   job_ready     block can accept a job (IDLE only)
//   job_svc       service mask of the offered job (all-zero mask = reject)
//   job_time      allotted time units
//   job_prio      priority flag, latched and echoed as done_prio
//   svc_done      station reports the current job finished (level)
//   ex            time exceeded (high in OVERTIME only)
//   busy          job in progress (RUN or OVERTIME)
//   elapsed       time units elapsed for the current or last job
//   done_valid    one-cycle pulse when a job closes
//   done_exceed   with done_valid: job ran past its allotment
//   done_reject   with done_valid: job rejected for an empty mask
//   done_prio     with done_valid: latched job_prio
//   overrun       with done_valid: elapsed - allotted, 0 if not exceeded
// ---------------------------------------------------------------------------
module service_time_monitor #(
    parameter int SVC_W    = 6,
    parameter int TIME_W   = 4,
    parameter int TICK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [SVC_W-1:0]  job_svc,
    input  logic [TIME_W-1:0] job_time,
    input  logic              job_prio,
    input  logic              svc_done,
    output logic              ex,
    output logic              busy,
    output logic [TIME_W:0]   elapsed,
    output logic              done_valid,
    output logic              done_exceed,
    output logic              done_reject,
    output logic              done_prio,
    output logic [TIME_W:0]   overrun
);

    // A counter of at least one bit keeps TICK_DIV == 1 legal.
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [TIME_W:0]   ELAPSED_MAX = '1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        OVERTIME = 2'd2,
        CLOSE    = 2'd3
    } state_t;

    state_t            state;
    logic [TICK_W-1:0] tick_cnt;
    logic [TIME_W-1:0] allot;
    logic              prio_l;

    logic tick_wrap;
    assign tick_wrap = (tick_cnt == TICK_LAST);

    // The service mask only decides accept-versus-reject, so it is examined
    // at the accept edge and not kept afterwards.
    // NOTE: every register below is updated with <= so all of them sample the
    // same pre-edge values; mixing in = would make the result order-dependent.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            allot       <= '0;
            prio_l      <= 1'b0;
            job_ready   <= 1'b1;
            ex          <= 1'b0;
            busy        <= 1'b0;
            elapsed     <= '0;
            done_valid  <= 1'b0;
            done_exceed <= 1'b0;
            done_reject <= 1'b0;
            done_prio   <= 1'b0;
            overrun     <= '0;
        end else begin
            done_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (job_valid) begin
                        allot       <= job_time;
                        prio_l      <= job_prio;
                        elapsed     <= '0;
                        tick_cnt    <= '0;
                        job_ready   <= 1'b0;
                        done_exceed <= 1'b0;
                        overrun     <= '0;
                        done_prio   <= 1'b0;
                        done_reject <= 1'b0;
                        if (job_svc == '0) begin
                            // Empty mask: close straight away, never busy.
                            state       <= CLOSE;
                            done_valid  <= 1'b1;
                            done_reject <= 1'b1;
                            done_prio   <= job_prio;
                        end else if (job_time == '0) begin
                            // Zero allotment is overtime from the first cycle.
                            state <= OVERTIME;
                            ex    <= 1'b1;
                            busy  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end

                RUN, OVERTIME: begin
                    if (svc_done) begin
                        // Completion beats a coinciding tick: elapsed and the
                        // tick counter stay at their pre-tick values.
                        state       <= CLOSE;
                        ex          <= 1'b0;
                        busy        <= 1'b0;
                        done_valid  <= 1'b1;
                        done_reject <= 1'b0;
                        done_prio   <= prio_l;
                        if (state == OVERTIME) begin
                            done_exceed <= 1'b1;
                            // Overtime is only entered once elapsed reached
                            // the allotment, so this cannot go negative.
                            overrun     <= elapsed - {1'b0, allot};
                        end else begin
                            done_exceed <= 1'b0;
                            overrun     <= '0;
                        end
                    end else begin
                        if (tick_wrap) begin
                            tick_cnt <= '0;
                            if (elapsed != ELAPSED_MAX) begin
                                elapsed <= elapsed + 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                        if (state == RUN && elapsed == {1'b0, allot}) begin
                            state <= OVERTIME;
                            ex    <= 1'b1;
                        end
                    end
                end

                CLOSE: begin
                    state     <= IDLE;
                    job_ready <= 1'b1;
                end

                default: begin
                    state     <= IDLE;
                    job_ready <= 1'b1;
                    ex        <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_service_time_monitor.sv
// ---------------------------------------------------------------------------
// tb_service_time_monitor
//
// Directed bench for service_time_monitor with TICK_DIV = 4. Each record of
// the job table describes one job and its hand-computed outcome. Cycle k
// counts from 0 at the first cycle after the accept edge, and svc_done is
// held high during cycle done_cyc only. The reset-mid-job sequence is written
// out by hand after the table.
// ---------------------------------------------------------------------------
module tb_service_time_monitor;

    localparam int SVC_W    = 6;
    localparam int TIME_W   = 4;
    localparam int TICK_DIV = 4;

    logic              clk;
    logic              rst;
    logic              job_valid;
    logic              job_ready;
    logic [SVC_W-1:0]  job_svc;
    logic [TIME_W-1:0] job_time;
    logic              job_prio;
    logic              svc_done;
    logic              ex;
    logic              busy;
    logic [TIME_W:0]   elapsed;
    logic              done_valid;
    logic              done_exceed;
    logic              done_reject;
    logic              done_prio;
    logic [TIME_W:0]   overrun;

    int n_cmp = 0;
    int n_err = 0;

    service_time_monitor #(
        .SVC_W   (SVC_W),
        .TIME_W  (TIME_W),
        .TICK_DIV(TICK_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .job_valid  (job_valid),
        .job_ready  (job_ready),
        .job_svc    (job_svc),
        .job_time   (job_time),
        .job_prio   (job_prio),
        .svc_done   (svc_done),
        .ex         (ex),
        .busy       (busy),
        .elapsed    (elapsed),
        .done_valid (done_valid),
        .done_exceed(done_exceed),
        .done_reject(done_reject),
        .done_prio  (done_prio),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    typedef struct {
        string             name;
        logic [SVC_W-1:0]  svc;
        logic [TIME_W-1:0] tm;
        logic              prio;
        int                done_cyc;     // cycle in which svc_done is high
        int                exp_elapsed;
        bit                exp_exceed;
        bit                exp_reject;
        int                exp_overrun;
        int                exp_ex_first; // first cycle with ex high, -1 = never
    } vec_t;

    vec_t vecs[$];

    // Called at a negedge with the block in IDLE; returns at the negedge of
    // the IDLE cycle after CLOSE, so the next job is offered back-to-back.
    task automatic run_job(input vec_t v);
        int ex_first;
        int ex_cnt;
        int busy_low;
        int early_done;
        int exp_ex_cnt;
        check({v.name, ".ready_before"}, int'(job_ready), 1);
        job_valid = 1'b1;
        job_svc   = v.svc;
        job_time  = v.tm;
        job_prio  = v.prio;
        @(negedge clk);
        job_valid = 1'b0;
        job_svc   = '0;
        job_time  = '0;
        job_prio  = 1'b0;
        ex_first   = -1;
        ex_cnt     = 0;
        busy_low   = 0;
        early_done = 0;
        if (!v.exp_reject) begin
            for (int k = 0; k <= v.done_cyc; k++) begin
                if (ex) begin
                    ex_cnt++;
                    if (ex_first < 0) ex_first = k;
                end
                if (!busy) busy_low++;
                if (done_valid) early_done++;
                svc_done = (k == v.done_cyc);
                @(negedge clk);
            end
            svc_done = 1'b0;
        end
        // CLOSE cycle
        exp_ex_cnt = (v.exp_ex_first < 0) ? 0 : v.done_cyc - v.exp_ex_first + 1;
        check({v.name, ".ex_first"},    ex_first,   v.exp_ex_first);
        check({v.name, ".ex_cycles"},   ex_cnt,     exp_ex_cnt);
        check({v.name, ".busy_low"},    busy_low,   0);
        check({v.name, ".early_done"},  early_done, 0);
        check({v.name, ".done_valid"},  int'(done_valid),  1);
        check({v.name, ".done_exceed"}, int'(done_exceed), int'(v.exp_exceed));
        check({v.name, ".done_reject"}, int'(done_reject), int'(v.exp_reject));
        check({v.name, ".done_prio"},   int'(done_prio),   int'(v.prio));
        check({v.name, ".overrun"},     int'(overrun),     v.exp_overrun);
        check({v.name, ".elapsed"},     int'(elapsed),     v.exp_elapsed);
        check({v.name, ".close_ex"},    int'(ex),          0);
        check({v.name, ".close_busy"},  int'(busy),        0);
        check({v.name, ".close_ready"}, int'(job_ready),   0);
        @(negedge clk);
        // Back in IDLE: pulse gone, results held.
        check({v.name, ".pulse_once"},  int'(done_valid),  0);
        check({v.name, ".idle_ready"},  int'(job_ready),   1);
        check({v.name, ".hold_elapsed"}, int'(elapsed),    v.exp_elapsed);
        check({v.name, ".hold_overrun"}, int'(overrun),    v.exp_overrun);
    endtask

    initial begin
        rst       = 1'b1;
        job_valid = 1'b0;
        job_svc   = '0;
        job_time  = '0;
        job_prio  = 1'b0;
        svc_done  = 1'b0;

        //        name          svc        tm prio done el ex rj ov exfirst
        vecs.push_back('{"on_time",   6'b000101, 4'd3,  1'b0, 8,   2,  1'b0, 1'b0, 0,  -1});
        vecs.push_back('{"late",      6'b000101, 4'd3,  1'b0, 20,  5,  1'b1, 1'b0, 2,  13});
        vecs.push_back('{"reject",    6'b000000, 4'd5,  1'b1, 0,   0,  1'b0, 1'b1, 0,  -1});
        vecs.push_back('{"zero_time", 6'b100000, 4'd0,  1'b1, 4,   1,  1'b1, 1'b0, 1,  0});
        vecs.push_back('{"tick_tie",  6'b111111, 4'd10, 1'b0, 7,   1,  1'b0, 1'b0, 0,  -1});
        vecs.push_back('{"saturate",  6'b000010, 4'd2,  1'b0, 140, 31, 1'b1, 1'b0, 29, 9});
        vecs.push_back('{"edge_run",  6'b000001, 4'd1,  1'b1, 4,   1,  1'b0, 1'b0, 0,  -1});
        vecs.push_back('{"edge_ovt",  6'b000001, 4'd1,  1'b0, 5,   1,  1'b1, 1'b0, 0,  5});
        vecs.push_back('{"instant",   6'b010000, 4'd3,  1'b0, 0,   0,  1'b0, 1'b0, 0,  -1});

        repeat (3) @(negedge clk);
        rst = 1'b0;
        // Reset state
        check("rst.job_ready",  int'(job_ready),  1);
        check("rst.ex",         int'(ex),         0);
        check("rst.busy",       int'(busy),       0);
        check("rst.elapsed",    int'(elapsed),    0);
        check("rst.done_valid", int'(done_valid), 0);
        check("rst.overrun",    int'(overrun),    0);

        foreach (vecs[i]) run_job(vecs[i]);

        // Reset in the middle of an overtime job: job dropped, no close pulse,
        // and a new job is taken on the very next cycle.
        job_valid = 1'b1;
        job_svc   = 6'b000011;
        job_time  = 4'd0;
        job_prio  = 1'b0;
        @(negedge clk);
        job_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("mid.ex_before", int'(ex), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid.ex",         int'(ex),         0);
        check("mid.busy",       int'(busy),       0);
        check("mid.job_ready",  int'(job_ready),  1);
        check("mid.done_valid", int'(done_valid), 0);
        check("mid.elapsed",    int'(elapsed),    0);
        job_valid = 1'b1;
        job_time  = 4'd2;
        @(negedge clk);
        job_valid = 1'b0;
        check("mid.new_busy",  int'(busy),      1);
        check("mid.new_ready", int'(job_ready), 0);
        check("mid.new_ex",    int'(ex),        0);
        svc_done = 1'b1;
        @(negedge clk);
        svc_done = 1'b0;
        check("mid.new_done",   int'(done_valid),  1);
        check("mid.new_exceed", int'(done_exceed), 0);

        // svc_done while idle is ignored.
        repeat (2) @(negedge clk);
        svc_done = 1'b1;
        @(negedge clk);
        svc_done = 1'b0;
        check("idle.ignore_done", int'(done_valid), 0);
        check("idle.ignore_busy", int'(busy),       0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
